// File: rtl/idu_imm_stage_pkg.sv
// Shared decode definitions for the IDU immediate stage: opcodes, imm_sel
// encoding and the skid-buffer state encoding.
`ifndef YSYX_23060251_IMM
`define YSYX_23060251_IMM 32
`endif

package idu_imm_stage_pkg;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] OP     = 7'b0110011;

  localparam int IMM_SEL_I = 1;
  localparam int IMM_SEL_S = 2;
  localparam int IMM_SEL_B = 3;
  localparam int IMM_SEL_U = 4;
  localparam int IMM_SEL_J = 5;

  typedef logic [5:1] imm_sel_t;

  localparam imm_sel_t SEL_NONE = 5'b00000;
  localparam imm_sel_t SEL_I_OH = 5'b00001;
  localparam imm_sel_t SEL_S_OH = 5'b00010;
  localparam imm_sel_t SEL_B_OH = 5'b00100;
  localparam imm_sel_t SEL_U_OH = 5'b01000;
  localparam imm_sel_t SEL_J_OH = 5'b10000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/idu_imm_stage_imm_type_dec.sv
// Opcode classifier: maps inst[6:0] to a one-hot immediate type and an
// illegal-opcode flag. R-type is legal but carries no immediate.
module imm_type_dec
  import idu_imm_stage_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_sel_t   imm_sel,
  output logic       illegal
);

  // opcode lookup; anything outside the table is flagged illegal
  always_comb begin
    imm_sel = SEL_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_IMM, LOAD, JALR, SYSTEM: imm_sel = SEL_I_OH;
      STORE:                      imm_sel = SEL_S_OH;
      BRANCH:                     imm_sel = SEL_B_OH;
      LUI, AUIPC:                 imm_sel = SEL_U_OH;
      JAL:                        imm_sel = SEL_J_OH;
      OP:                         imm_sel = SEL_NONE;
      default:                    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/igu.sv
// Core immediate generator: assembles the RV32 immediate selected by the
// one-hot imm_sel and sign-extends it to IMM_W; zero when no type is selected.
module igu
  import idu_imm_stage_pkg::*;
#(
  parameter int IMM_W = `YSYX_23060251_IMM
) (
  input  logic [31:7]      inst,
  input  imm_sel_t         imm_sel,
  output logic [IMM_W-1:0] imm
);

  logic [31:0] imm32_s;

  // immediate field assembly per instruction format
  always_comb begin
    imm32_s = 32'd0;
    case (imm_sel)
      SEL_I_OH: imm32_s = {{20{inst[31]}}, inst[31:20]};
      SEL_S_OH: imm32_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      SEL_B_OH: imm32_s = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      SEL_U_OH: imm32_s = {inst[31:12], 12'd0};
      SEL_J_OH: imm32_s = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:  imm32_s = 32'd0;
    endcase
    imm = IMM_W'($signed(imm32_s));
  end

endmodule

// File: rtl/idu_imm_stage.sv
// Decode-stage front end: classifies the opcode, generates the immediate and
// holds results in a 2-entry skid buffer toward EXU. Optional performance
// counters are enabled with YSYX_23060251_IDU_PERF_CNT_EN.
module idu_imm_stage
  import idu_imm_stage_pkg::*;
#(
  parameter int IMM_W = `YSYX_23060251_IMM,
  parameter int PC_W  = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_inst_i,
  input  logic [PC_W-1:0]  in_pc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PC_W-1:0]  out_pc_o,
  output logic [31:0]      out_inst_o,
  output logic [5:1]       out_imm_sel_o,
  output logic [IMM_W-1:0] out_imm_o,
  output logic             out_illegal_o,
  input  logic             flush_i
`ifdef YSYX_23060251_IDU_PERF_CNT_EN
  ,
  output logic [31:0]      perf_dec_cnt_o,
  output logic [31:0]      perf_stall_cnt_o
`endif
);

  skid_state_e      state_r;
  skid_state_e      state_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             accept_s;
  logic             retire_s;
  logic             load_main_s;
  logic             skid_to_main_s;
  logic             load_skid_s;

  imm_sel_t         dec_sel_s;
  logic             dec_ill_s;
  logic [IMM_W-1:0] dec_imm_s;

  logic [PC_W-1:0]  main_pc_r;
  logic [31:0]      main_inst_r;
  imm_sel_t         main_sel_r;
  logic [IMM_W-1:0] main_imm_r;
  logic             main_ill_r;
  logic [PC_W-1:0]  skid_pc_r;
  logic [31:0]      skid_inst_r;
  imm_sel_t         skid_sel_r;
  logic [IMM_W-1:0] skid_imm_r;
  logic             skid_ill_r;

  imm_type_dec u_dec (
    .opcode  (in_inst_i[6:0]),
    .imm_sel (dec_sel_s),
    .illegal (dec_ill_s)
  );

  igu #(.IMM_W(IMM_W)) u_igu (
    .inst    (in_inst_i[31:7]),
    .imm_sel (dec_sel_s),
    .imm     (dec_imm_s)
  );

  assign accept_s = in_valid_i & in_ready_r;
  assign retire_s = out_valid_r & out_ready_i;

  // next-state and entry-load control; flush wins over any handshake
  always_comb begin
    state_nxt_s    = state_r;
    load_main_s    = 1'b0;
    skid_to_main_s = 1'b0;
    load_skid_s    = 1'b0;
    if (flush_i) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s = ST_ONE;
            load_main_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && retire_s) begin
            state_nxt_s = ST_ONE;
            load_main_s = 1'b1;
          end else if (accept_s) begin
            state_nxt_s = ST_TWO;
            load_skid_s = 1'b1;
          end else if (retire_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (retire_s) begin
            state_nxt_s    = ST_ONE;
            skid_to_main_s = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // state register; ready/valid are registered from the next state
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_TWO);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
    end
  end

  // main entry: new beat when main frees up, otherwise promote the skid entry
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      main_pc_r   <= '0;
      main_inst_r <= 32'd0;
      main_sel_r  <= SEL_NONE;
      main_imm_r  <= '0;
      main_ill_r  <= 1'b0;
    end else if (load_main_s) begin
      main_pc_r   <= in_pc_i;
      main_inst_r <= in_inst_i;
      main_sel_r  <= dec_sel_s;
      main_imm_r  <= dec_imm_s;
      main_ill_r  <= dec_ill_s;
    end else if (skid_to_main_s) begin
      main_pc_r   <= skid_pc_r;
      main_inst_r <= skid_inst_r;
      main_sel_r  <= skid_sel_r;
      main_imm_r  <= skid_imm_r;
      main_ill_r  <= skid_ill_r;
    end
  end

  // skid entry catches the beat accepted while main is stalled
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      skid_pc_r   <= '0;
      skid_inst_r <= 32'd0;
      skid_sel_r  <= SEL_NONE;
      skid_imm_r  <= '0;
      skid_ill_r  <= 1'b0;
    end else if (load_skid_s) begin
      skid_pc_r   <= in_pc_i;
      skid_inst_r <= in_inst_i;
      skid_sel_r  <= dec_sel_s;
      skid_imm_r  <= dec_imm_s;
      skid_ill_r  <= dec_ill_s;
    end
  end

  assign in_ready_o    = in_ready_r;
  assign out_valid_o   = out_valid_r;
  assign out_pc_o      = main_pc_r;
  assign out_inst_o    = main_inst_r;
  assign out_imm_sel_o = main_sel_r;
  assign out_imm_o     = main_imm_r;
  assign out_illegal_o = main_ill_r;

`ifdef YSYX_23060251_IDU_PERF_CNT_EN
  logic [31:0] dec_cnt_r;
  logic [31:0] stall_cnt_r;

  // free-running event counters; only reset clears them
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      dec_cnt_r   <= 32'd0;
      stall_cnt_r <= 32'd0;
    end else begin
      if (accept_s && !flush_i) begin
        dec_cnt_r <= dec_cnt_r + 32'd1;
      end
      if (in_valid_i && !in_ready_r) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign perf_dec_cnt_o   = dec_cnt_r;
  assign perf_stall_cnt_o = stall_cnt_r;
`endif

endmodule
